updown_counter_mod: RTL
=======================

Name: updown_counter_mod

Overview:
- Parametrised successor to the lab's 6-bit up/down counter.
- Adds:
  - configurable width, modulus and step;
  - per-direction wrap-or-saturate policy;
  - synchronous load and count enable;
  - registered overflow/underflow strobes.
- Used as a general timing/event counter in lab datapaths. Feeds display and FSM blocks.

Parameters:
- N, 6, counter width in bits.
- MODULUS, 2**N, count range 0..MODULUS-1. Legal range: 2 <= MODULUS <= 2**N.
- STEP, 1, increment/decrement amount per enabled cycle. Legal range: 1 <= STEP <= MODULUS-1.
- UP_WRAP, 1, 1 = wrap past MODULUS-1 when counting up; 0 = saturate at MODULUS-1.
- DOWN_WRAP, 0, 1 = wrap below 0 when counting down; 0 = saturate at 0.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  count enable; a count step occurs only when en=1.
- mode  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- load_val  in  N  value loaded when load=1.
- out  out  N  current count, registered.
- ovf  out  1  registered 1-cycle strobe: an up step crossed MODULUS-1 (wrapped or saturated).
- unf  out  1  registered 1-cycle strobe: a down step crossed 0 (wrapped or saturated).
- is_max  out  1  combinational, out == MODULUS-1.
- is_zero  out  1  combinational, out == 0.

Behaviour:
- Reset (reset=0, asynchronous, any time): out=0, ovf=0, unf=0, prescaler count=0. Released synchronously to clk. The first update happens on the first rising edge with reset=1.
- Priority per rising edge: load > en > hold.
- load=1:
  - out <= min(load_val, MODULUS-1); load_val above MODULUS-1 clamps to MODULUS-1.
  - ovf=0, unf=0.
  - load ignores en and mode.
- load=0, en=1, mode=1 (up):
  - sum = out + STEP, computed in N+1 bits.
  - sum <= MODULUS-1: out <= sum; ovf=0.
  - sum > MODULUS-1 with UP_WRAP=1: out <= sum - MODULUS; ovf=1.
  - sum > MODULUS-1 with UP_WRAP=0: out <= MODULUS-1; ovf=1. This includes the case where out is already MODULUS-1; ovf repeats every enabled cycle.
- load=0, en=1, mode=0 (down):
  - out >= STEP: out <= out - STEP; unf=0.
  - out < STEP with DOWN_WRAP=1: out <= out + MODULUS - STEP, computed in N+1 bits; unf=1.
  - out < STEP with DOWN_WRAP=0: out <= 0; unf=1. Repeats while held at 0.
- load=0, en=0: out holds; ovf=0, unf=0.
- ovf and unf:
  - never both 1 in the same cycle;
  - asserted the cycle after the causing edge, aligned with the new out value;
  - cleared on the next edge unless re-triggered.
- Latency: out reflects load or a step one clock after the sampling edge. is_max and is_zero follow out combinationally.
- Defaults (UP_WRAP=1, DOWN_WRAP=0, STEP=1) reproduce the previous generation: up wraps max->0, down sticks at 0.
- Direction may change on any cycle. Each edge is evaluated independently; no pipeline state.

Optional Feature:
- Macro: UPDOWN_PRESCALER_EN.
- When defined:
  - Extra parameter PRESCALE, default 4, legal >= 1.
  - Internal counter of width $clog2(PRESCALE)+1 counts enabled cycles.
  - A count step occurs only on the enabled cycle where the prescaler equals PRESCALE-1. The prescaler then returns to 0.
  - en=0 freezes the prescaler.
  - load=1 clears the prescaler to 0.
  - ovf/unf are generated only on actual steps.
- When undefined: the prescaler is absent; every enabled cycle steps, equivalent to PRESCALE=1.

Test Plan:
- Reset: N=4, out driven to 9, assert reset=0 mid-cycle -> out=0, ovf=0, unf=0 immediately, before the next clk edge. Release -> holds 0 while en=0.
- Up wrap: defaults N=4, load 14, en=1, mode=1 for 3 cycles -> out 15, 0 (ovf=1 that cycle), 1; is_max=1 only when out=15.
- Down saturate: defaults, load 1, mode=0, en=1 for 3 cycles -> out 0, 0 (unf=1), 0 (unf=1); is_zero=1.
- Modulus/step wrap both ways: N=4, MODULUS=10, STEP=3, UP_WRAP=1, DOWN_WRAP=1:
  - load 8, up -> out 1 with ovf=1.
  - down from 1 -> out 8 with unf=1.
- Load priority and clamp: MODULUS=10, load=1 with load_val=13, en=1, mode=1 -> out=9, ovf=0.
- Up saturate plus prescaler (UPDOWN_PRESCALER_EN, PRESCALE=3), UP_WRAP=0, MODULUS=10:
  - from out=8, en held 1 -> out steps to 9 on the 3rd enabled cycle, then stays 9 with ovf=1 every 3rd enabled cycle.
  - en=0 for 2 cycles mid-count delays the next step by exactly 2 cycles.

Source files
------------

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with wrap/saturate policy, load, enable and overflow strobes.
// Optional prescaler on the count enable is built when UPDOWN_PRESCALER_EN is defined.
module updown_counter_mod #(
    parameter int unsigned N         = 6,
    parameter int unsigned MODULUS   = 2 ** N,
    parameter int unsigned STEP      = 1,
    parameter bit          UP_WRAP   = 1'b1,
    parameter bit          DOWN_WRAP = 1'b0
`ifdef UPDOWN_PRESCALER_EN
    ,
    parameter int unsigned PRESCALE  = 4
`endif
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         mode,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] out,
    output logic         ovf,
    output logic         unf,
    output logic         is_max,
    output logic         is_zero
);

    localparam int unsigned W1 = N + 1;
    localparam logic [N:0] ModMax  = W1'(MODULUS - 1);
    localparam logic [N:0] ModFull = W1'(MODULUS);
    localparam logic [N:0] StepW   = W1'(STEP);

    logic [N-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;
    logic         step_en;
    logic [N:0]   ext;
    logic [N:0]   sum;
    logic [N-1:0] wrap_up;
    logic [N-1:0] wrap_dn;

`ifdef UPDOWN_PRESCALER_EN
    localparam int unsigned PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] PreLast = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    assign step_en = en && (pre_q == PreLast);

    always_comb begin
        pre_d = pre_q;
        if (load) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = (pre_q == PreLast) ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign step_en = en;
`endif

    // All arithmetic is done one bit wider so the crossing test cannot alias.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        ext     = {1'b0, count_q};
        sum     = ext + StepW;
        wrap_up = N'(sum - ModFull);
        wrap_dn = N'(ext + ModFull - StepW);
        if (load) begin
            count_d = ({1'b0, load_val} > ModMax) ? ModMax[N-1:0] : load_val;
        end else if (step_en) begin
            if (mode) begin
                if (sum > ModMax) begin
                    ovf_d   = 1'b1;
                    count_d = UP_WRAP ? wrap_up : ModMax[N-1:0];
                end else begin
                    count_d = sum[N-1:0];
                end
            end else begin
                if (ext < StepW) begin
                    unf_d   = 1'b1;
                    count_d = DOWN_WRAP ? wrap_dn : '0;
                end else begin
                    count_d = N'(ext - StepW);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign out     = count_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign is_max  = (count_q == ModMax[N-1:0]);
    assign is_zero = (count_q == '0);

endmodule
